// File: rtl/st7735_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | st7735_pkg                                                       |
// | Shared ST7735 link definitions: command codes, receiver decode   |
// | state encoding and RGB565 field widths.                          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package st7735_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int RGB565_R_W = 5;
  localparam int RGB565_G_W = 6;
  localparam int RGB565_B_W = 5;
  localparam int RGB565_W   = RGB565_R_W + RGB565_G_W + RGB565_B_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CASET    = 3'd1,
    ST_RASET    = 3'd2,
    ST_RAMWR_HI = 3'd3,
    ST_RAMWR_LO = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_byte_rx                                                      |
// | Synchronises the raw SPI pins, detects SCK rising edges and      |
// | assembles MSB-first bytes tagged with their D/C level.           |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module spi_byte_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cs,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc
);

  logic [1:0] r_cs_s;
  logic [1:0] r_sclk_s;
  logic [1:0] r_mosi_s;
  logic [1:0] r_dc_s;
  logic       r_sclk_prev;
  logic       r_rise;
  logic       r_cs_d;
  logic       r_mosi_d;
  logic       r_dc_d;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic       r_byte_valid;
  logic [7:0] r_byte;
  logic       r_dc;

  // Two-flop synchronisers on every raw pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_s   <= 2'b00;
      r_sclk_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_dc_s   <= 2'b00;
    end else begin
      r_cs_s   <= {r_cs_s[0],   i_cs};
      r_sclk_s <= {r_sclk_s[0], i_sclk};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_dc_s   <= {r_dc_s[0],   i_dc};
    end
  end

  // Edge detect; mosi/dc/cs captured from the same synchronised cycle as the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_cs_d      <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_dc_d      <= 1'b0;
    end else begin
      r_sclk_prev <= r_sclk_s[1];
      r_rise      <= r_sclk_s[1] & ~r_sclk_prev;
      r_cs_d      <= r_cs_s[1];
      r_mosi_d    <= r_mosi_s[1];
      r_dc_d      <= r_dc_s[1];
    end
  end

  // Shift register and bit counter; deselect drops only the partial byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 7'd0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'd0;
      r_dc         <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (r_cs_d) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 7'd0;
      end else if (r_rise) begin
        r_shift   <= {r_shift[5:0], r_mosi_d};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_valid <= 1'b1;
          r_byte       <= {r_shift, r_mosi_d};
          r_dc         <= r_dc_d;
        end
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;
  assign o_dc         = r_dc;

endmodule
`default_nettype wire

// File: rtl/st7735_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | st7735_rx                                                        |
// | Panel-side receiver of the ST7735 SPI link: decodes CASET/RASET/ |
// | RAMWR and strobes each RGB565 pixel with its window address.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module st7735_rx
  import st7735_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                oled_cs,
  input  logic                oled_clk,
  input  logic                oled_mosi,
  input  logic                oled_dc,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output logic                pix_valid,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [RGB565_W-1:0] pix_color,
  output logic                frame_done
);

  localparam logic [X_W-1:0] C_XE_RST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] C_YE_RST = Y_W'(HEIGHT - 1);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_dc;

  spi_byte_rx u_byte_rx (
    .clk          (clk),
    .reset        (reset),
    .i_cs         (oled_cs),
    .i_sclk       (oled_clk),
    .i_mosi       (oled_mosi),
    .i_dc         (oled_dc),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_dc         (w_dc)
  );

  rx_state_t           r_state,     w_state_nx;
  logic [1:0]          r_arg_idx,   w_arg_idx_nx;
  logic [7:0]          r_arg_start, w_arg_start_nx;
  logic [X_W-1:0]      r_xs, r_xe, r_x, w_xs_nx, w_xe_nx, w_x_nx;
  logic [Y_W-1:0]      r_ys, r_ye, r_y, w_ys_nx, w_ye_nx, w_y_nx;
  logic [7:0]          r_hi,        w_hi_nx;
  logic                r_cmd_valid, w_cmd_valid_nx;
  logic [7:0]          r_cmd_byte,  w_cmd_byte_nx;
  logic                r_pix_valid, w_pix_valid_nx;
  logic [X_W-1:0]      r_pix_x,     w_pix_x_nx;
  logic [Y_W-1:0]      r_pix_y,     w_pix_y_nx;
  logic [RGB565_W-1:0] r_pix_color, w_pix_color_nx;
  logic                r_frame_done, w_frame_done_nx;

  // Decode state, window, address and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_arg_idx    <= 2'd0;
      r_arg_start  <= 8'd0;
      r_xs         <= '0;
      r_xe         <= C_XE_RST;
      r_ys         <= '0;
      r_ye         <= C_YE_RST;
      r_x          <= '0;
      r_y          <= '0;
      r_hi         <= 8'd0;
      r_cmd_valid  <= 1'b0;
      r_cmd_byte   <= 8'd0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_color  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_arg_idx    <= w_arg_idx_nx;
      r_arg_start  <= w_arg_start_nx;
      r_xs         <= w_xs_nx;
      r_xe         <= w_xe_nx;
      r_ys         <= w_ys_nx;
      r_ye         <= w_ye_nx;
      r_x          <= w_x_nx;
      r_y          <= w_y_nx;
      r_hi         <= w_hi_nx;
      r_cmd_valid  <= w_cmd_valid_nx;
      r_cmd_byte   <= w_cmd_byte_nx;
      r_pix_valid  <= w_pix_valid_nx;
      r_pix_x      <= w_pix_x_nx;
      r_pix_y      <= w_pix_y_nx;
      r_pix_color  <= w_pix_color_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  // Next-state decode: commands restart from any state, data bytes act per state
  always_comb begin
    w_state_nx      = r_state;
    w_arg_idx_nx    = r_arg_idx;
    w_arg_start_nx  = r_arg_start;
    w_xs_nx         = r_xs;
    w_xe_nx         = r_xe;
    w_ys_nx         = r_ys;
    w_ye_nx         = r_ye;
    w_x_nx          = r_x;
    w_y_nx          = r_y;
    w_hi_nx         = r_hi;
    w_cmd_valid_nx  = 1'b0;
    w_cmd_byte_nx   = r_cmd_byte;
    w_pix_valid_nx  = 1'b0;
    w_pix_x_nx      = r_pix_x;
    w_pix_y_nx      = r_pix_y;
    w_pix_color_nx  = r_pix_color;
    w_frame_done_nx = 1'b0;

    if (w_byte_valid) begin
      if (!w_dc) begin
        w_cmd_valid_nx = 1'b1;
        w_cmd_byte_nx  = w_byte;
        w_arg_idx_nx   = 2'd0;
        w_hi_nx        = 8'd0;
        case (w_byte)
          CMD_CASET: w_state_nx = ST_CASET;
          CMD_RASET: w_state_nx = ST_RASET;
          CMD_RAMWR: begin
            w_state_nx = ST_RAMWR_HI;
            w_x_nx     = r_xs;
            w_y_nx     = r_ys;
          end
          default:   w_state_nx = ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_CASET, ST_RASET: begin
            w_arg_idx_nx = r_arg_idx + 2'd1;
            if (r_arg_idx == 2'd1) begin
              w_arg_start_nx = w_byte;
            end
            // Window commits only once the end address low byte arrives
            if (r_arg_idx == 2'd3) begin
              w_state_nx = ST_IDLE;
              if (r_state == ST_CASET) begin
                w_xs_nx = X_W'(r_arg_start);
                w_xe_nx = X_W'(w_byte);
              end else begin
                w_ys_nx = Y_W'(r_arg_start);
                w_ye_nx = Y_W'(w_byte);
              end
            end
          end
          ST_RAMWR_HI: begin
            w_hi_nx    = w_byte;
            w_state_nx = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            w_pix_valid_nx = 1'b1;
            w_pix_x_nx     = r_x;
            w_pix_y_nx     = r_y;
            w_pix_color_nx = {r_hi, w_byte};
            w_state_nx     = ST_RAMWR_HI;
            // Raster advance; an inverted window simply wraps until it hits the end
            if (r_x == r_xe) begin
              w_x_nx = r_xs;
              if (r_y == r_ye) begin
                w_y_nx          = r_ys;
                w_frame_done_nx = 1'b1;
              end else begin
                w_y_nx = r_y + Y_W'(1);
              end
            end else begin
              w_x_nx = r_x + X_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_byte   = r_cmd_byte;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_color  = r_pix_color;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
